// File: rtl/board_updater_stack_pkg.sv
// Shared board types: piece codes, move codes, history record and FSM states.
package board_pkg;

  // Record fields are sized for boards up to 1024 squares and 6-bit pieces.
  localparam int unsigned REC_IDX_W   = 10;
  localparam int unsigned REC_PIECE_W = 6;

  localparam logic [REC_PIECE_W-1:0] PIECE_NONE   = 6'b000000;
  localparam logic [REC_PIECE_W-1:0] PIECE_PAWN   = 6'b000001;
  localparam logic [REC_PIECE_W-1:0] PIECE_ROOK   = 6'b000010;
  localparam logic [REC_PIECE_W-1:0] PIECE_KNIGHT = 6'b000100;
  localparam logic [REC_PIECE_W-1:0] PIECE_BISHOP = 6'b001000;
  localparam logic [REC_PIECE_W-1:0] PIECE_QUEEN  = 6'b010000;
  localparam logic [REC_PIECE_W-1:0] PIECE_KING   = 6'b100000;

  localparam logic [1:0] CASTLE_NONE = 2'b00;
  localparam logic [1:0] CASTLE_QS   = 2'b01;
  localparam logic [1:0] CASTLE_KS   = 2'b10;

  localparam logic [4:0] EP_NONE = 5'b00001;
  localparam logic [4:0] EP_UL   = 5'b00010;
  localparam logic [4:0] EP_UR   = 5'b00100;
  localparam logic [4:0] EP_DL   = 5'b01000;
  localparam logic [4:0] EP_DR   = 5'b10000;

  typedef struct packed {
    logic [REC_IDX_W-1:0]   fromSq;
    logic [REC_IDX_W-1:0]   toSq;
    logic [REC_PIECE_W-1:0] mover;
    logic [REC_PIECE_W-1:0] captured;
    logic                   color;
    logic [1:0]             castling;
    logic [4:0]             enpassant;
  } move_rec_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_COMMIT
  } state_t;

  // Back-rank layout R N B Q K B N R for an 8-column board.
  function automatic logic [REC_PIECE_W-1:0] backRankPiece(input int unsigned col);
    case (col)
      0, 7:    return PIECE_ROOK;
      1, 6:    return PIECE_KNIGHT;
      2, 5:    return PIECE_BISHOP;
      3:       return PIECE_QUEEN;
      4:       return PIECE_KING;
      default: return PIECE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/move_history_lifo.sv
// Circular LIFO of move records; a push when full overwrites the oldest entry.
module move_history_lifo
  import board_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  move_rec_t        pushRec,
  output move_rec_t        topRec,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wrPtr;
  move_rec_t        mem [DEPTH];

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign topRec = mem[wrPtr - PTR_W'(1)];

  // Write pointer wraps freely, so when full it already points at the oldest slot.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wrPtr <= '0;
      count <= '0;
    end else if (push) begin
      wrPtr <= wrPtr + PTR_W'(1);
      if (!full) count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      wrPtr <= wrPtr - PTR_W'(1);
      count <= count - CNT_W'(1);
    end
  end

  // Record storage, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (rst_n && !clear && push) mem[wrPtr] <= pushRec;
  end

endmodule

// File: rtl/board_updater_stack.sv
// Board state holder: applies moves (incl. castling, en passant) and undoes them from history.
module board_updater_stack
  import board_pkg::*;
#(
  parameter int unsigned ROWS       = 8,
  parameter int unsigned COLS       = 8,
  parameter int unsigned PIECE_W    = 6,
  parameter int unsigned HIST_DEPTH = 16,
  localparam int unsigned SQ    = ROWS * COLS,
  localparam int unsigned IDX_W = $clog2(SQ),
  localparam int unsigned CNT_W = $clog2(HIST_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    init,
  input  logic                    move_valid,
  input  logic                    undo_valid,
  output logic                    ready,
  input  logic                    color_type,
  input  logic [SQ-1:0]           initialPosition,
  input  logic [SQ-1:0]           movedPosition,
  input  logic [PIECE_W-1:0]      movingPiece,
  input  logic [PIECE_W-1:0]      capturedPiece,
  input  logic [1:0]              castling,
  input  logic [4:0]              enpassant,
  output logic [SQ-1:0]           enable_out,
  output logic [SQ-1:0]           color_out,
  output logic [SQ*PIECE_W-1:0]   board_flat,
  output logic [CNT_W-1:0]        hist_count,
  output logic                    hist_empty,
  output logic                    hist_full,
  output logic                    err
);

  state_t               state;
  logic                 isUndo;
  logic [SQ-1:0]        reqFrom, reqTo;
  logic [PIECE_W-1:0]   reqMover, reqCap;
  logic                 reqColor;
  logic [1:0]           reqCastle;
  logic [4:0]           reqEp;

  logic [PIECE_W-1:0]   board [SQ];
  logic [SQ-1:0]        colr;

  logic [IDX_W-1:0]     fromIdx, toIdx, dFrom, dTo, dRowBase;
  logic [PIECE_W-1:0]   dMover, dCap;
  logic                 dColor, dOk, fromOneHot, toOneHot;
  logic [1:0]           dCastle;
  logic [4:0]           dEp;

  logic [IDX_W-1:0]     cFrom, cTo, cEpSq, cRookCorner, cRookMid;
  logic [PIECE_W-1:0]   cMover, cCap;
  logic                 cColor, cOk;
  logic [1:0]           cCastle;
  logic [4:0]           cEp;
  logic                 epActive, castleActive;

  move_rec_t            histTop, pushRec;
  logic                 histPush, histPop;

  assign ready        = (state == ST_IDLE) && !init;
  assign color_out    = colr;
  assign epActive     = (cEp == EP_UL) || (cEp == EP_UR) || (cEp == EP_DL) || (cEp == EP_DR);
  assign castleActive = (cCastle == CASTLE_KS) || (cCastle == CASTLE_QS);
  assign histPush     = (state == ST_COMMIT) && !isUndo && cOk;
  assign histPop      = (state == ST_COMMIT) && isUndo && cOk;

  // Flatten the board array onto the output buses.
  always_comb begin
    enable_out = '0;
    board_flat = '0;
    for (int unsigned i = 0; i < SQ; i++) begin
      enable_out[i]                     = |board[i];
      board_flat[i*PIECE_W +: PIECE_W]  = board[i];
    end
  end

  // Decode: one-hot to index, legality, and pick move or history record as source.
  always_comb begin
    fromIdx = '0;
    toIdx   = '0;
    for (int unsigned i = 0; i < SQ; i++) begin
      if (reqFrom[i]) fromIdx = IDX_W'(i);
      if (reqTo[i])   toIdx   = IDX_W'(i);
    end
    fromOneHot = (reqFrom != '0) && ((reqFrom & (reqFrom - SQ'(1))) == '0);
    toOneHot   = (reqTo != '0) && ((reqTo & (reqTo - SQ'(1))) == '0);
    if (isUndo) begin
      dFrom   = IDX_W'(histTop.fromSq);
      dTo     = IDX_W'(histTop.toSq);
      dMover  = PIECE_W'(histTop.mover);
      dCap    = PIECE_W'(histTop.captured);
      dColor  = histTop.color;
      dCastle = histTop.castling;
      dEp     = histTop.enpassant;
      dOk     = !hist_empty;
    end else begin
      dFrom   = fromIdx;
      dTo     = toIdx;
      dMover  = reqMover;
      dCap    = reqCap;
      dColor  = reqColor;
      dCastle = reqCastle;
      dEp     = reqEp;
      dOk     = fromOneHot && toOneHot && (board[fromIdx] == reqMover) && (colr[fromIdx] == reqColor);
    end
    dRowBase = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (dTo >= IDX_W'(r * COLS)) dRowBase = IDX_W'(r * COLS);
    end
  end

  // History record built from the committed operation.
  always_comb begin
    pushRec           = '0;
    pushRec.fromSq    = REC_IDX_W'(cFrom);
    pushRec.toSq      = REC_IDX_W'(cTo);
    pushRec.mover     = REC_PIECE_W'(cMover);
    pushRec.captured  = REC_PIECE_W'(cCap);
    pushRec.color     = cColor;
    pushRec.castling  = cCastle;
    pushRec.enpassant = cEp;
  end

  move_history_lifo #(.DEPTH(HIST_DEPTH)) uHist (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (init),
    .push    (histPush),
    .pop     (histPop),
    .pushRec (pushRec),
    .topRec  (histTop),
    .count   (hist_count),
    .empty   (hist_empty),
    .full    (hist_full)
  );

  // Control FSM plus board writes: IDLE latches, DECODE resolves squares, COMMIT writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      err         <= 1'b0;
      isUndo      <= 1'b0;
      reqFrom     <= '0;
      reqTo       <= '0;
      reqMover    <= '0;
      reqCap      <= '0;
      reqColor    <= 1'b0;
      reqCastle   <= CASTLE_NONE;
      reqEp       <= EP_NONE;
      cFrom       <= '0;
      cTo         <= '0;
      cEpSq       <= '0;
      cRookCorner <= '0;
      cRookMid    <= '0;
      cMover      <= '0;
      cCap        <= '0;
      cColor      <= 1'b0;
      cOk         <= 1'b0;
      cCastle     <= CASTLE_NONE;
      cEp         <= EP_NONE;
      colr        <= '0;
      for (int unsigned i = 0; i < SQ; i++) board[i] <= '0;
    end else if (init) begin
      state <= ST_IDLE;
      err   <= 1'b0;
      for (int unsigned i = 0; i < SQ; i++) begin
        board[i] <= PIECE_W'(PIECE_NONE);
        colr[i]  <= 1'b0;
        if ((i / COLS == 1) || (i / COLS == ROWS - 2)) begin
          board[i] <= PIECE_W'(PIECE_PAWN);
          colr[i]  <= (i / COLS == 1);
        end
        if ((COLS == 8) && ((i / COLS == 0) || (i / COLS == ROWS - 1))) begin
          board[i] <= PIECE_W'(backRankPiece(i % COLS));
          colr[i]  <= (i / COLS == 0);
        end
      end
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (undo_valid) begin
            isUndo <= 1'b1;
            state  <= ST_DECODE;
          end else if (move_valid) begin
            isUndo    <= 1'b0;
            reqFrom   <= initialPosition;
            reqTo     <= movedPosition;
            reqMover  <= movingPiece;
            reqCap    <= capturedPiece;
            reqColor  <= color_type;
            reqCastle <= castling;
            reqEp     <= enpassant;
            state     <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          cFrom       <= dFrom;
          cTo         <= dTo;
          cMover      <= dMover;
          cCap        <= dCap;
          cColor      <= dColor;
          cCastle     <= dCastle;
          cEp         <= dEp;
          cOk         <= dOk;
          cEpSq       <= dColor ? (dTo - IDX_W'(COLS)) : (dTo + IDX_W'(COLS));
          cRookCorner <= (dCastle == CASTLE_KS) ? (dRowBase + IDX_W'(COLS - 1)) : dRowBase;
          cRookMid    <= (dCastle == CASTLE_KS) ? (dTo - IDX_W'(1)) : (dTo + IDX_W'(1));
          state       <= ST_COMMIT;
        end
        ST_COMMIT: begin
          state <= ST_IDLE;
          if (!cOk) begin
            err <= 1'b1;
          end else if (!isUndo) begin
            board[cFrom] <= PIECE_W'(PIECE_NONE);
            colr[cFrom]  <= 1'b0;
            board[cTo]   <= cMover;
            colr[cTo]    <= cColor;
            if (epActive) begin
              board[cEpSq] <= PIECE_W'(PIECE_NONE);
              colr[cEpSq]  <= 1'b0;
            end
            if (castleActive) begin
              board[cRookCorner] <= PIECE_W'(PIECE_NONE);
              colr[cRookCorner]  <= 1'b0;
              board[cRookMid]    <= PIECE_W'(PIECE_ROOK);
              colr[cRookMid]     <= cColor;
            end
          end else begin
            board[cFrom] <= cMover;
            colr[cFrom]  <= cColor;
            if (epActive || (cCap == '0)) begin
              board[cTo] <= PIECE_W'(PIECE_NONE);
              colr[cTo]  <= 1'b0;
            end else begin
              board[cTo] <= cCap;
              colr[cTo]  <= !cColor;
            end
            if (epActive) begin
              board[cEpSq] <= PIECE_W'(PIECE_PAWN);
              colr[cEpSq]  <= !cColor;
            end
            if (castleActive) begin
              board[cRookMid]    <= PIECE_W'(PIECE_NONE);
              colr[cRookMid]     <= 1'b0;
              board[cRookCorner] <= PIECE_W'(PIECE_ROOK);
              colr[cRookCorner]  <= cColor;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_updater_stack.sv
// Directed bench for board_updater_stack on an 8x8 board with a 4-deep history.
module tb_board_updater_stack;

  localparam int unsigned SQ = 64;
  localparam logic [5:0] P = 6'b000001;
  localparam logic [5:0] R = 6'b000010;
  localparam logic [5:0] N = 6'b000100;
  localparam logic [5:0] B = 6'b001000;
  localparam logic [5:0] Q = 6'b010000;
  localparam logic [5:0] K = 6'b100000;
  localparam logic [5:0] E = 6'b000000;
  localparam logic [63:0] INIT_EN  = 64'hFFFF_0000_0000_FFFF;
  localparam logic [63:0] INIT_COL = 64'h0000_0000_0000_FFFF;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           init = 1'b0;
  logic           move_valid = 1'b0;
  logic           undo_valid = 1'b0;
  logic           ready;
  logic           color_type = 1'b0;
  logic [63:0]    initialPosition = '0;
  logic [63:0]    movedPosition = '0;
  logic [5:0]     movingPiece = '0;
  logic [5:0]     capturedPiece = '0;
  logic [1:0]     castling = '0;
  logic [4:0]     enpassant = 5'b00001;
  logic [63:0]    enable_out;
  logic [63:0]    color_out;
  logic [383:0]   board_flat;
  logic [2:0]     hist_count;
  logic           hist_empty, hist_full, err;

  int errors = 0;
  int checks = 0;

  board_updater_stack #(.ROWS(8), .COLS(8), .PIECE_W(6), .HIST_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .init(init), .move_valid(move_valid), .undo_valid(undo_valid),
    .ready(ready), .color_type(color_type), .initialPosition(initialPosition),
    .movedPosition(movedPosition), .movingPiece(movingPiece), .capturedPiece(capturedPiece),
    .castling(castling), .enpassant(enpassant), .enable_out(enable_out), .color_out(color_out),
    .board_flat(board_flat), .hist_count(hist_count), .hist_empty(hist_empty),
    .hist_full(hist_full), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] sq(input int i);
    return board_flat[i*6 +: 6];
  endfunction

  function automatic logic [63:0] oh(input int i);
    logic [63:0] one;
    one = 64'd1;
    return one << i;
  endfunction

  // Drives one request, scrambles inputs after acceptance, returns #1 after E2.
  task automatic issue(input logic undo, input logic alsoMove, input logic [63:0] fromV,
                       input logic [63:0] toV, input logic [5:0] mv, input logic [5:0] cap,
                       input logic col, input logic [1:0] cs, input logic [4:0] ep);
    int waitCycles;
    waitCycles = 0;
    @(negedge clk);
    while (!ready && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL ready_wait got=%b want=1", ready); end
    undo_valid      = undo;
    move_valid      = !undo || alsoMove;
    initialPosition = fromV;
    movedPosition   = toV;
    movingPiece     = mv;
    capturedPiece   = cap;
    color_type      = col;
    castling        = cs;
    enpassant       = ep;
    @(posedge clk);
    @(negedge clk);
    undo_valid      = 1'b0;
    move_valid      = 1'b0;
    initialPosition = '1;
    movedPosition   = '0;
    movingPiece     = '0;
    capturedPiece   = '0;
    color_type      = ~col;
    castling        = 2'b11;
    enpassant       = 5'b00000;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic doMove(input int f, input int t, input logic [5:0] mv, input logic [5:0] cap,
                        input logic col, input logic [1:0] cs, input logic [4:0] ep);
    issue(1'b0, 1'b0, oh(f), oh(t), mv, cap, col, cs, ep);
  endtask

  task automatic doUndo();
    issue(1'b1, 1'b0, '0, '0, E, E, 1'b0, 2'b00, 5'b00001);
  endtask

  task automatic doInit();
    @(negedge clk);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (board_flat !== '0) begin errors++; $display("FAIL reset_board got=%h want=0", board_flat); end
    checks++; if (enable_out !== '0) begin errors++; $display("FAIL reset_enable got=%h want=0", enable_out); end
    checks++; if (hist_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", hist_count); end
    checks++; if (hist_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b want=1", hist_empty); end
    checks++; if (hist_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b want=0", hist_full); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", err); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", ready); end
  endtask

  task automatic test_init();
    doInit();
    checks++; if (enable_out !== INIT_EN) begin errors++; $display("FAIL init_enable got=%h want=%h", enable_out, INIT_EN); end
    checks++; if (color_out !== INIT_COL) begin errors++; $display("FAIL init_color got=%h want=%h", color_out, INIT_COL); end
    checks++; if (sq(0) !== R) begin errors++; $display("FAIL init_sq0 got=%b want=%b", sq(0), R); end
    checks++; if (sq(3) !== Q) begin errors++; $display("FAIL init_sq3 got=%b want=%b", sq(3), Q); end
    checks++; if (sq(4) !== K) begin errors++; $display("FAIL init_sq4 got=%b want=%b", sq(4), K); end
    checks++; if (sq(57) !== N) begin errors++; $display("FAIL init_sq57 got=%b want=%b", sq(57), N); end
    checks++; if (sq(60) !== K) begin errors++; $display("FAIL init_sq60 got=%b want=%b", sq(60), K); end
    checks++; if (sq(52) !== P) begin errors++; $display("FAIL init_sq52 got=%b want=%b", sq(52), P); end
  endtask

  task automatic test_pawn_move();
    doInit();
    doMove(12, 28, P, E, 1'b1, 2'b00, 5'b00001);
    checks++; if (sq(28) !== P) begin errors++; $display("FAIL pawn_sq28 got=%b want=%b", sq(28), P); end
    checks++; if (color_out[28] !== 1'b1) begin errors++; $display("FAIL pawn_col28 got=%b want=1", color_out[28]); end
    checks++; if (enable_out[12] !== 1'b0) begin errors++; $display("FAIL pawn_en12 got=%b want=0", enable_out[12]); end
    checks++; if (hist_count !== 3'd1) begin errors++; $display("FAIL pawn_count got=%0d want=1", hist_count); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL pawn_ready got=%b want=1", ready); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL pawn_err got=%b want=0", err); end
    doUndo();
    checks++; if (enable_out !== INIT_EN) begin errors++; $display("FAIL pawn_undo_enable got=%h want=%h", enable_out, INIT_EN); end
    checks++; if (color_out !== INIT_COL) begin errors++; $display("FAIL pawn_undo_color got=%h want=%h", color_out, INIT_COL); end
    checks++; if (sq(12) !== P) begin errors++; $display("FAIL pawn_undo_sq12 got=%b want=%b", sq(12), P); end
    checks++; if (hist_count !== 3'd0) begin errors++; $display("FAIL pawn_undo_count got=%0d want=0", hist_count); end
  endtask

  task automatic test_capture();
    doInit();
    doMove(9, 49, P, P, 1'b1, 2'b00, 5'b00001);
    doMove(49, 56, P, R, 1'b1, 2'b00, 5'b00001);
    checks++; if (sq(56) !== P) begin errors++; $display("FAIL cap_sq56 got=%b want=%b", sq(56), P); end
    checks++; if (color_out[56] !== 1'b1) begin errors++; $display("FAIL cap_col56 got=%b want=1", color_out[56]); end
    checks++; if (sq(49) !== E) begin errors++; $display("FAIL cap_sq49 got=%b want=0", sq(49)); end
    checks++; if (hist_count !== 3'd2) begin errors++; $display("FAIL cap_count got=%0d want=2", hist_count); end
    doUndo();
    checks++; if (sq(56) !== R) begin errors++; $display("FAIL cap_undo_sq56 got=%b want=%b", sq(56), R); end
    checks++; if (color_out[56] !== 1'b0) begin errors++; $display("FAIL cap_undo_col56 got=%b want=0", color_out[56]); end
    checks++; if (sq(49) !== P) begin errors++; $display("FAIL cap_undo_sq49 got=%b want=%b", sq(49), P); end
    checks++; if (color_out[49] !== 1'b1) begin errors++; $display("FAIL cap_undo_col49 got=%b want=1", color_out[49]); end
    doUndo();
    checks++; if (color_out[49] !== 1'b0) begin errors++; $display("FAIL cap_undo2_col49 got=%b want=0", color_out[49]); end
    checks++; if (sq(9) !== P) begin errors++; $display("FAIL cap_undo2_sq9 got=%b want=%b", sq(9), P); end
  endtask

  task automatic test_castle();
    doInit();
    doMove(5, 21, B, E, 1'b1, 2'b00, 5'b00001);
    doMove(6, 23, N, E, 1'b1, 2'b00, 5'b00001);
    doMove(4, 6, K, E, 1'b1, 2'b10, 5'b00001);
    checks++; if (sq(6) !== K) begin errors++; $display("FAIL castle_sq6 got=%b want=%b", sq(6), K); end
    checks++; if (sq(5) !== R) begin errors++; $display("FAIL castle_sq5 got=%b want=%b", sq(5), R); end
    checks++; if (color_out[5] !== 1'b1) begin errors++; $display("FAIL castle_col5 got=%b want=1", color_out[5]); end
    checks++; if (sq(7) !== E) begin errors++; $display("FAIL castle_sq7 got=%b want=0", sq(7)); end
    checks++; if (sq(4) !== E) begin errors++; $display("FAIL castle_sq4 got=%b want=0", sq(4)); end
    doUndo();
    checks++; if (sq(4) !== K) begin errors++; $display("FAIL castle_undo_sq4 got=%b want=%b", sq(4), K); end
    checks++; if (sq(7) !== R) begin errors++; $display("FAIL castle_undo_sq7 got=%b want=%b", sq(7), R); end
    checks++; if (color_out[7] !== 1'b1) begin errors++; $display("FAIL castle_undo_col7 got=%b want=1", color_out[7]); end
    checks++; if (enable_out[5] !== 1'b0 || enable_out[6] !== 1'b0) begin errors++; $display("FAIL castle_undo_en56 got=%b%b want=00", enable_out[6], enable_out[5]); end
    checks++; if (hist_count !== 3'd2) begin errors++; $display("FAIL castle_undo_count got=%0d want=2", hist_count); end
  endtask

  task automatic test_enpassant();
    doInit();
    doMove(12, 36, P, E, 1'b1, 2'b00, 5'b00001);
    doMove(51, 35, P, E, 1'b0, 2'b00, 5'b00001);
    doMove(36, 43, P, P, 1'b1, 2'b00, 5'b00100);
    checks++; if (enable_out[35] !== 1'b0) begin errors++; $display("FAIL ep_en35 got=%b want=0", enable_out[35]); end
    checks++; if (sq(43) !== P) begin errors++; $display("FAIL ep_sq43 got=%b want=%b", sq(43), P); end
    checks++; if (color_out[43] !== 1'b1) begin errors++; $display("FAIL ep_col43 got=%b want=1", color_out[43]); end
    checks++; if (sq(36) !== E) begin errors++; $display("FAIL ep_sq36 got=%b want=0", sq(36)); end
    doUndo();
    checks++; if (sq(35) !== P) begin errors++; $display("FAIL ep_undo_sq35 got=%b want=%b", sq(35), P); end
    checks++; if (color_out[35] !== 1'b0) begin errors++; $display("FAIL ep_undo_col35 got=%b want=0", color_out[35]); end
    checks++; if (sq(36) !== P) begin errors++; $display("FAIL ep_undo_sq36 got=%b want=%b", sq(36), P); end
    checks++; if (enable_out[43] !== 1'b0) begin errors++; $display("FAIL ep_undo_en43 got=%b want=0", enable_out[43]); end
  endtask

  task automatic test_history_overflow();
    doInit();
    for (int i = 0; i < 5; i++) doMove(8 + i, 16 + i, P, E, 1'b1, 2'b00, 5'b00001);
    checks++; if (hist_full !== 1'b1) begin errors++; $display("FAIL ovf_full got=%b want=1", hist_full); end
    checks++; if (hist_count !== 3'd4) begin errors++; $display("FAIL ovf_count got=%0d want=4", hist_count); end
    for (int i = 0; i < 4; i++) doUndo();
    checks++; if (sq(12) !== P || sq(9) !== P) begin errors++; $display("FAIL ovf_undo_restored got=%b/%b want=%b", sq(12), sq(9), P); end
    checks++; if (enable_out[20:17] !== 4'b0000) begin errors++; $display("FAIL ovf_undo_cleared got=%b want=0000", enable_out[20:17]); end
    checks++; if (hist_empty !== 1'b1) begin errors++; $display("FAIL ovf_empty got=%b want=1", hist_empty); end
    doUndo();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovf_err got=%b want=1", err); end
    checks++; if (sq(16) !== P) begin errors++; $display("FAIL ovf_first_kept got=%b want=%b", sq(16), P); end
    checks++; if (enable_out[8] !== 1'b0) begin errors++; $display("FAIL ovf_sq8 got=%b want=0", enable_out[8]); end
    checks++; if (hist_count !== 3'd0) begin errors++; $display("FAIL ovf_count_end got=%0d want=0", hist_count); end
  endtask

  task automatic test_errors();
    doInit();
    doMove(28, 36, P, E, 1'b1, 2'b00, 5'b00001);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_empty_pulse got=%b want=1", err); end
    checks++; if (enable_out !== INIT_EN) begin errors++; $display("FAIL err_empty_board got=%h want=%h", enable_out, INIT_EN); end
    checks++; if (hist_count !== 3'd0) begin errors++; $display("FAIL err_empty_count got=%0d want=0", hist_count); end
    @(posedge clk);
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_one_cycle got=%b want=0", err); end
    issue(1'b0, 1'b0, oh(12) | oh(13), oh(28), P, E, 1'b1, 2'b00, 5'b00001);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_onehot got=%b want=1", err); end
    doMove(52, 44, P, E, 1'b1, 2'b00, 5'b00001);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_colour got=%b want=1", err); end
    checks++; if (sq(52) !== P || enable_out[44] !== 1'b0) begin errors++; $display("FAIL err_colour_board got=%b/%b want=%b/0", sq(52), enable_out[44], P); end
    doMove(12, 20, N, E, 1'b1, 2'b00, 5'b00001);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_piece got=%b want=1", err); end
  endtask

  task automatic test_priority();
    doInit();
    doMove(12, 28, P, E, 1'b1, 2'b00, 5'b00001);
    issue(1'b1, 1'b1, oh(13), oh(29), P, E, 1'b1, 2'b00, 5'b00001);
    checks++; if (sq(12) !== P || sq(28) !== E) begin errors++; $display("FAIL prio_undo got=%b/%b want=%b/0", sq(12), sq(28), P); end
    checks++; if (sq(13) !== P || sq(29) !== E) begin errors++; $display("FAIL prio_nomove got=%b/%b want=%b/0", sq(13), sq(29), P); end
    checks++; if (hist_count !== 3'd0) begin errors++; $display("FAIL prio_count got=%0d want=0", hist_count); end
  endtask

  task automatic test_reset_mid();
    doInit();
    doMove(12, 28, P, E, 1'b1, 2'b00, 5'b00001);
    @(negedge clk);
    move_valid      = 1'b1;
    initialPosition = oh(13);
    movedPosition   = oh(29);
    movingPiece     = P;
    capturedPiece   = E;
    color_type      = 1'b1;
    castling        = 2'b00;
    enpassant       = 5'b00001;
    @(posedge clk);
    @(negedge clk);
    move_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b want=0", ready); end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (board_flat !== '0) begin errors++; $display("FAIL rstmid_board got=%h want=0", board_flat); end
    checks++; if (hist_count !== 3'd0 || hist_empty !== 1'b1) begin errors++; $display("FAIL rstmid_hist got=%0d/%b want=0/1", hist_count, hist_empty); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b want=1", ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (enable_out !== '0 || err !== 1'b0) begin errors++; $display("FAIL rstmid_after got=%h/%b want=0/0", enable_out, err); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_pawn_move();
    test_capture();
    test_castle();
    test_enpassant();
    test_history_overflow();
    test_errors();
    test_priority();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule

// File: doc/board_updater_stack.md
# board_updater_stack

Parametrised successor to the board updater. Holds the full board (one-hot piece type plus colour per square) and applies one move at a time through a valid/ready handshake, including castling and en passant. Pushes every committed move onto a bounded history stack, so any number of moves up to HIST_DEPTH can be undone in order. Sits between move generation/selection and the per-square enable and piece-register consumers.

## Interface
- ROWS, 8, board rows; ROWS ≥ 4
- COLS, 8, board columns; COLS ≥ 3
- PIECE_W, 6, one-hot piece width: bit0 pawn, 1 rook, 2 knight, 3 bishop, 4 queen, 5 king; 0 means empty
- HIST_DEPTH, 16, undo records kept; power of two ≥ 2
- Derived: SQ = ROWS*COLS, IDX_W = $clog2(SQ), CNT_W = $clog2(HIST_DEPTH+1)

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- init  in  1  load the start position and clear history; takes priority over everything except reset
- move_valid  in  1  move request
- undo_valid  in  1  undo request
- ready  out  1  high only in IDLE with init low
- color_type  in  1  mover colour: 1 white, 0 black
- initialPosition  in  SQ  one-hot source square
- movedPosition  in  SQ  one-hot destination square
- movingPiece  in  PIECE_W  moving piece
- capturedPiece  in  PIECE_W  captured piece; 0 if none
- castling  in  2  00 none, 01 queen side, 10 king side
- enpassant  in  5  00001 none, 00010 UL, 00100 UR, 01000 DL, 10000 DR
- enable_out  out  SQ  square occupied
- color_out  out  SQ  owner colour of each square; 0 when empty
- board_flat  out  SQ*PIECE_W  piece of square i in [i*PIECE_W +: PIECE_W]
- hist_count  out  CNT_W  records held
- hist_empty, hist_full  out  1  history flags
- err  out  1  one-cycle pulse on a rejected request

## Operation
- Square index = row*COLS + col. White sits on rows 0–1 and moves toward higher indices.
- FSM states:
  - IDLE: accept a request.
  - DECODE: one-hot→index conversion and legality checks.
  - COMMIT: write the board and update history.
  - Then return to IDLE.
- If undo_valid and move_valid are both high in IDLE, undo wins. The move is not accepted.
- A move is rejected with err, leaving board and history unchanged, if any of these hold:
  - from or to is not one-hot;
  - board[from] ≠ movingPiece;
  - color_out[from] ≠ color_type.
- Move commit:
  - board[to] takes movingPiece and color_type; board[from] is cleared.
  - En passant: the captured pawn is removed at to−COLS (white) or to+COLS (black); to must be empty.
  - King-side castling: the rook moves from the row's col COLS−1 to to−1.
  - Queen-side castling: the rook moves from col 0 to to+1.
  - A record {from, to, movingPiece, capturedPiece, color_type, castling, enpassant} is pushed.
- History full on a push: the oldest record is overwritten. hist_count stays at HIST_DEPTH.
- Undo commit:
  - The top record is popped; the mover is restored at from.
  - to gets capturedPiece with the opposite colour, or becomes empty for en passant or no capture.
  - An en-passant pawn is restored at its square; a castled rook is returned to its corner.
  - Undo with the history empty gives err and no change.
- init (one cycle): all squares are cleared.
  - Pawns go on rows 1 and ROWS−2.
  - If COLS == 8, back ranks get R N B Q K B N R on rows 0 and ROWS−1, king at col 4.
  - Rows 0–1 are white. History is cleared and the FSM goes to IDLE, aborting any operation in flight.

## Timing
- Reset values: all board outputs 0, hist_count 0, hist_empty 1, hist_full 0, err 0, state IDLE, ready 1 from the first cycle after reset.
- The request is sampled at accept edge E0, when valid & ready. ready is low during DECODE and COMMIT.
- New board and hist_* values are visible after E2. ready is high again after E2.
- Sustained throughput: one operation per 3 cycles.
- err is high for exactly the one cycle following E2.
- Request inputs are don't-care after E0; they are latched at E0.
- rst_n low at any edge overrides everything and restores reset values, including mid-operation.

## Structure
- Package board_pkg holds:
  - piece one-hot constants (PIECE_PAWN … PIECE_KING);
  - castling and enpassant codes;
  - the move-record packed struct and the FSM state enum.
- Sub-module move_history_lifo holds the history stack:
  - circular LIFO of records, DEPTH parameter;
  - push with overwrite-oldest when full, pop, count, empty and full flags;
  - synchronous active-low reset; synchronous clear for init.

## Test plan
- init, then a white pawn move idx 12→28 → after E2, sq28 holds pawn (000001, white) and sq12 is empty; hist_count = 1. Then undo → position restored, hist_count = 0.
- White pawn at 49 captures a black rook at 56 (moving 000001, captured 000010) → sq56 holds a white pawn; undo → sq56 holds a black rook and sq49 a white pawn.
- White king-side castle, king 4→6 with 5 and 6 empty → rook moves 7→5; undo → king back at 4, rook back at 7.
- En passant: white pawn 36→43 with a black pawn at 35 → sq35 is cleared; undo → black pawn restored at 35.
- HIST_DEPTH = 4: apply 5 legal moves → hist_full = 1, count = 4. Then 5 undos → the first 4 succeed; the 5th gives err = 1 with no change; the first move is not undone.
- Error and priority cases:
  - a move from an empty square gives err and no state change;
  - move_valid and undo_valid together give the undo;
  - rst_n low during COMMIT gives an empty board.
